// File: rtl/switch_reg_pkg.sv
// Shared types and helpers for the switch register access path.
//   state_e    : register access controller FSM states
//   port_slice : extracts one decoder's read-data slice from a flattened bus
package switch_reg_pkg;

    // Upper bounds for the flattened read-data bus handled by port_slice.
    localparam int unsigned MAX_BUS_W  = 1024;
    localparam int unsigned MAX_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Returns slice idx of a bus built from width-bit fields; caller truncates.
    function automatic logic [MAX_DATA_W-1:0] port_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          idx,
        input int unsigned          width
    );
        logic [MAX_BUS_W-1:0] shifted;
        shifted = bus >> (idx * width);
        return shifted[MAX_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/reg_access_ctrl.sv
// Host-side master for the per-port register decoders on the select bus.
// Accepts one request at a time, drives sel_en/wr_rd_s/addr/wdata to all
// decoders, waits for the addressed decoder's ack (bounded by a timeout) and
// returns read data or an error on the response channel.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   req_valid/req_ready        : request handshake (req_ready = state is IDLE)
//   req_wr/req_addr/req_wdata  : request payload
//   rsp_valid/rsp_ready        : response handshake
//   rsp_rdata/rsp_err          : response payload
//   sel_en/wr_rd_s/addr/wdata  : shared decoder select bus
//   ack_in/rd_data_in          : per-decoder ack and read data
module reg_access_ctrl
    import switch_reg_pkg::*;
#(
    parameter int unsigned NUM_OF_PORTS   = 4,
    parameter int unsigned W_WIDTH        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_wr,
    input  logic [$clog2(NUM_OF_PORTS)-1:0] req_addr,
    input  logic [W_WIDTH-1:0]              req_wdata,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [W_WIDTH-1:0]              rsp_rdata,
    output logic                            rsp_err,
    output logic                            sel_en,
    output logic                            wr_rd_s,
    output logic [$clog2(NUM_OF_PORTS)-1:0] addr,
    output logic [W_WIDTH-1:0]              wdata,
    input  logic [NUM_OF_PORTS-1:0]         ack_in,
    input  logic [NUM_OF_PORTS*W_WIDTH-1:0] rd_data_in
);

    localparam int unsigned AW = $clog2(NUM_OF_PORTS);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sel_en_q, sel_en_d;
    logic               wr_rd_s_q, wr_rd_s_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [W_WIDTH-1:0] wdata_q, wdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [W_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [NUM_OF_PORTS-1:0] ack_shift;
    logic                    ack_sel;
    logic [W_WIDTH-1:0]      rd_slice;
    logic                    addr_out_of_range;

    // Ack and read data of the currently addressed decoder; shift keeps the
    // select in range for non-power-of-2 port counts.
    assign ack_shift = ack_in >> addr_q;
    assign ack_sel   = ack_shift[0];
    assign rd_slice  = W_WIDTH'(port_slice(MAX_BUS_W'(rd_data_in), 32'(addr_q), W_WIDTH));

    assign addr_out_of_range = (32'(req_addr) >= NUM_OF_PORTS);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_en_d    = sel_en_q;
        wr_rd_s_d   = wr_rd_s_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_rd_s_d = req_wr;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    if (addr_out_of_range) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = RESP;
                    end else begin
                        sel_en_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (ack_sel) begin
                    rsp_rdata_d = wr_rd_s_q ? '0 : rd_slice;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    sel_en_d    = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    sel_en_d    = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                sel_en_d = 1'b0;
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                sel_en_d    = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_en_q    <= 1'b0;
            wr_rd_s_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_en_q    <= sel_en_d;
            wr_rd_s_q   <= wr_rd_s_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign sel_en    = sel_en_q;
    assign wr_rd_s   = wr_rd_s_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl: behavioural one-cycle-registered decoders on the
// select bus, a register-file model for expected read data, and a second
// 3-port instance for the out-of-range address case.
module tb_reg_access_ctrl;

    localparam int NP = 4;
    localparam int W  = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic           req_valid, req_ready, req_wr;
    logic [1:0]     req_addr;
    logic [W-1:0]   req_wdata;
    logic           rsp_valid, rsp_ready, rsp_err;
    logic [W-1:0]   rsp_rdata;
    logic           sel_en, wr_rd_s;
    logic [1:0]     addr;
    logic [W-1:0]   wdata;
    logic [NP-1:0]  ack_in;
    logic [NP*W-1:0] rd_data_in;

    reg_access_ctrl #(.NUM_OF_PORTS(NP), .W_WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .sel_en(sel_en), .wr_rd_s(wr_rd_s), .addr(addr), .wdata(wdata),
        .ack_in(ack_in), .rd_data_in(rd_data_in)
    );

    // Three-port instance: address 3 is out of range.
    logic           req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_err3;
    logic [1:0]     req_addr3;
    logic [W-1:0]   rsp_rdata3;
    logic           sel_en3, wr_rd_s3;
    logic [1:0]     addr3;
    logic [W-1:0]   wdata3;
    logic [2:0]     ack_in3;
    logic [3*W-1:0] rd_data_in3;
    assign ack_in3     = '0;
    assign rd_data_in3 = '0;

    reg_access_ctrl #(.NUM_OF_PORTS(3), .W_WIDTH(W), .TIMEOUT_CYCLES(16)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_wr(1'b0),
        .req_addr(req_addr3), .req_wdata(8'h00),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
        .sel_en(sel_en3), .wr_rd_s(wr_rd_s3), .addr(addr3), .wdata(wdata3),
        .ack_in(ack_in3), .rd_data_in(rd_data_in3)
    );

    // Decoder environment: registered ack, writes while selected, backdoor load.
    logic         ack_en;
    logic         bd_we;
    logic [1:0]   bd_idx;
    logic [W-1:0] bd_val;
    logic [W-1:0] dec_reg [NP];
    logic [NP-1:0] ack_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            ack_q[i] <= ack_en && sel_en && (int'(addr) == i);
            if (ack_en && sel_en && wr_rd_s && (int'(addr) == i))
                dec_reg[i] <= wdata;
        end
        if (bd_we) dec_reg[bd_idx] <= bd_val;
    end

    assign ack_in = ack_q;
    always_comb begin
        rd_data_in = '0;
        for (int i = 0; i < NP; i++) rd_data_in[i*W +: W] = dec_reg[i];
    end

    // Expected register contents, updated from completed writes.
    logic [W-1:0] model [NP];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic backdoor(input logic [1:0] idx, input logic [W-1:0] val);
        bd_we = 1'b1; bd_idx = idx; bd_val = val;
        tick();
        bd_we = 1'b0;
        model[idx] = val;
    endtask

    // One complete transaction on the 4-port instance, checked against the model.
    task automatic do_txn(input logic wr, input logic [1:0] a, input logic [W-1:0] d,
                          input logic ack_on, input int hold);
        int cyc, sel_cnt, guard;
        logic [W-1:0] exp_rd;
        logic exp_err;
        guard = 0;
        while (!req_ready && guard < 50) begin tick(); guard++; end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        ack_en    = ack_on;
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0;
        check("sel_en_n1", 32'(sel_en), 32'd1);
        check("addr_n1", 32'(addr), 32'(a));
        check("wr_rd_s_n1", 32'(wr_rd_s), 32'(wr));
        check("wdata_n1", 32'(wdata), 32'(d));
        check("req_ready_busy", 32'(req_ready), 32'd0);
        cyc = 1; sel_cnt = 0;
        while (!rsp_valid && cyc < 40) begin
            if (sel_en) sel_cnt++;
            tick();
            cyc++;
        end
        exp_err = !ack_on;
        exp_rd  = (wr || !ack_on) ? 8'h00 : model[a];
        check("rsp_latency", 32'(cyc), ack_on ? 32'd3 : 32'd17);
        check("sel_en_cycles", 32'(sel_cnt), ack_on ? 32'd2 : 32'd16);
        check("sel_en_resp", 32'(sel_en), 32'd0);
        check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        if (wr && ack_on) model[a] = d;
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", 32'(rsp_rdata), 32'(exp_rd));
            check("hold_err", 32'(rsp_err), 32'(exp_err));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_done", 32'(rsp_valid), 32'd0);
        check("idle_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int saw;
        rst_n = 1'b0;
        req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
        req_valid3 = 0; req_addr3 = 0; rsp_ready3 = 0;
        ack_en = 1'b1; bd_we = 0; bd_idx = 0; bd_val = 0;
        backdoor(2'd0, 8'h11);
        backdoor(2'd1, 8'h22);
        backdoor(2'd2, 8'hA5);
        backdoor(2'd3, 8'h44);

        // Reset state.
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_sel_en", 32'(sel_en), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // Directed: read port 2, write port 1, readback, timeout.
        do_txn(1'b0, 2'd2, 8'h00, 1'b1, 0);
        do_txn(1'b1, 2'd1, 8'h3C, 1'b1, 0);
        check("dec1_written", 32'(dec_reg[1]), 32'h3C);
        do_txn(1'b0, 2'd1, 8'h00, 1'b1, 0);
        do_txn(1'b0, 2'd3, 8'h00, 1'b0, 0);

        // Backpressure, fresh data in decoder, then back-to-back same-port read.
        do_txn(1'b0, 2'd2, 8'h00, 1'b1, 5);
        backdoor(2'd2, 8'h5A);
        do_txn(1'b0, 2'd2, 8'h00, 1'b1, 0);
        do_txn(1'b0, 2'd2, 8'h00, 1'b1, 0);

        // Randomized transactions.
        for (int t = 0; t < 30; t++) begin
            do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   8'($urandom_range(0, 255)), 1'($urandom_range(0, 7) != 0),
                   $urandom_range(0, 3));
        end

        // Reset asserted mid-ACCESS.
        ack_en = 1'b1;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 2'd0;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_sel_en", 32'(sel_en), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        saw = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (rsp_valid) saw++;
        end
        check("no_rsp_after_reset", 32'(saw), 32'd0);

        // Out-of-range address on the three-port instance.
        req_valid3 = 1'b1; req_addr3 = 2'd3;
        tick();
        req_valid3 = 1'b0;
        check("oor_sel_en", 32'(sel_en3), 32'd0);
        check("oor_rsp_valid", 32'(rsp_valid3), 32'd1);
        check("oor_rsp_err", 32'(rsp_err3), 32'd1);
        check("oor_rsp_rdata", 32'(rsp_rdata3), 32'd0);
        rsp_ready3 = 1'b1;
        tick();
        rsp_ready3 = 1'b0;
        check("oor_done", 32'(rsp_valid3), 32'd0);
        check("oor_ready", 32'(req_ready3), 32'd1);
        check("oor_sel_en_after", 32'(sel_en3), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_access_ctrl.md
Name: reg_access_ctrl

Overview:
Upstream master for the per-port register decoders of the simple switch. It accepts one host register transaction at a time over a valid/ready request channel. It drives the shared sel_en / wr_rd_s / addr / wdata select bus to all NUM_OF_PORTS decoders and waits for the addressed decoder's ack. It then returns read data or an error on a valid/ready response channel.

Parameters:
NUM_OF_PORTS, 4, number of port register decoders on the select bus (>=2)
W_WIDTH, 8, register data width
TIMEOUT_CYCLES, 16, max cycles in ACCESS without ack before error (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock, reset asynchronous and active-low
req_valid  in  1  host request valid
req_ready  out  1  controller can accept request
req_wr  in  1  1 = write, 0 = read
req_addr  in  $clog2(NUM_OF_PORTS)  target port register
req_wdata  in  W_WIDTH  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_rdata  out  W_WIDTH  read data (0 for writes/errors)
rsp_err  out  1  timeout or out-of-range address
sel_en  out  1  select strobe to decoders
wr_rd_s  out  1  1 = write, 0 = read, to decoders
addr  out  $clog2(NUM_OF_PORTS)  decoder address
wdata  out  W_WIDTH  write data to port registers
ack_in  in  NUM_OF_PORTS  per-decoder ack, bit i from decoder REG_ADDR=i
rd_data_in  in  NUM_OF_PORTS*W_WIDTH  per-decoder rd_data, slice i = [i*W_WIDTH +: W_WIDTH]

Behaviour:
- Reset (async, rst_n low): state IDLE. req_ready=1, all other outputs 0, timeout counter 0. Assertion mid-transaction aborts it immediately; no response is issued.
- All outputs are registered, except req_ready, which is decoded from the state register (state==IDLE).
- FSM states: IDLE, ACCESS, RESP.
- IDLE: on req_valid && req_ready (cycle n), latch req_wr, req_addr and req_wdata onto wr_rd_s, addr and wdata.
  - If req_addr >= NUM_OF_PORTS (non-power-of-2 only): go to RESP with rsp_err=1, rsp_rdata=0. sel_en is never raised.
  - Otherwise: sel_en=1 from cycle n+1, go to ACCESS, clear counter.
- ACCESS: sel_en held high; addr, wr_rd_s and wdata held stable. Each cycle, sample ack_in[addr].
  - ack seen: capture rd_data_in slice[addr] into rsp_rdata (forced 0 when wr_rd_s=1), rsp_err=0, sel_en=0, go to RESP.
  - No ack: counter increments. When counter reaches TIMEOUT_CYCLES-1 without ack: sel_en=0, rsp_err=1, rsp_rdata=0, go to RESP.
  - ack_in bits other than addr are ignored.
- Nominal latency with the one-cycle-registered decoder:
  - handshake at n; sel_en at n+1; decoder ack at n+2; rsp_valid at n+3.
  - Decoder wr_en is high in n+2 and n+3; the write is idempotent.
- RESP: rsp_valid=1, sel_en=0. rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready. Then rsp_valid=0, return to IDLE.
  - Minimum one cycle in RESP guarantees the decoder ack has fallen before the next sel_en rise. No stale-ack capture on back-to-back accesses to the same address.
- req_ready=0 outside IDLE. req_valid is ignored there.
- On the cycle of return to IDLE, a new request may be accepted. Back-to-back throughput is one transaction per 4 cycles with rsp_ready tied high.
- addr, wr_rd_s and wdata keep their last values in IDLE/RESP; decoders only qualify them with sel_en.
- Counter width $clog2(TIMEOUT_CYCLES); it saturates, never wraps.

Decomposition:
- Shared package `switch_reg_pkg`: FSM state enum (IDLE/ACCESS/RESP) and function port_slice(rd_data_in, idx) returning the W_WIDTH slice.
- No sub-module. Per-port reg_decoder instances are connected alongside at the switch top, not instantiated inside this block.

Test Plan:
- Read port 2: preload decoder 2 reg_data2port_in=8'hA5; req rd addr=2 at cycle n -> sel_en n+1..n+2, rsp_valid n+3, rsp_rdata=8'hA5, rsp_err=0.
- Write port 1 with 8'h3C -> decoder 1 wr_en high 2 cycles, wdata=8'h3C throughout, rsp_valid with rsp_rdata=0, rsp_err=0.
- Timeout: tie ack_in=0, TIMEOUT_CYCLES=16 -> sel_en high exactly 16 cycles, then rsp_err=1, rsp_rdata=0.
- Backpressure then back-to-back: hold rsp_ready=0 for 5 cycles -> rsp fields stable and req_ready=0. Release; immediately issue a second read of the same port -> second response carries fresh data, no early capture.
- Reset mid-ACCESS: drop rst_n at n+2 -> sel_en=0, rsp_valid=0, req_ready=1 asynchronously; no response after rst_n release.
- NUM_OF_PORTS=3, req addr=3 -> no sel_en pulse, rsp_err=1 one cycle after acceptance.
